// File: rtl/r5p_trace_encoder_pkg.sv
// Shared types for the R5P retired-instruction trace encoder.
// Holds the record layout, the size encoding and the opcode-size helper.
package r5p_trace_encoder_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned GNUM = 32;
  localparam int unsigned GLOG = $clog2(GNUM);

  // Instruction size in bytes; SizNone only appears in an all-zero record.
  typedef enum logic [2:0] {
    SizNone = 3'd0,
    Siz2    = 3'd2,
    Siz4    = 3'd4
  } siz_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
    siz_e            siz;
    logic            gpr_vld;
    logic [GLOG-1:0] gpr_idx;
    logic [XLEN-1:0] gpr_dat;
    logic            mem_vld;
    logic            mem_wen;
    logic [XLEN-1:0] mem_adr;
    logic [XLEN-1:0] mem_dat;
  } rec_t;

  function automatic siz_e opsiz(logic [31:0] ins);
    return (ins[1:0] == 2'b11) ? Siz4 : Siz2;
  endfunction

endpackage

// File: rtl/r5p_trace_encoder_if.sv
// Valid/ready record stream from the trace encoder toward a trace sink.
interface r5p_trace_encoder_if;
  import r5p_trace_encoder_pkg::*;

  logic vld;
  logic rdy;
  rec_t rec;

  modport master (output vld, output rec, input rdy);
  modport slave  (input vld, input rec, output rdy);

endinterface

// File: rtl/r5p_trace_encoder_fifo.sv
// Synchronous record FIFO; pointers carry an extra wrap bit to tell full from empty.
module r5p_trace_encoder_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw:0]      wptr_q, rptr_q;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  // Zero when empty so the stream output is clean out of reset.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[Aw-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + (Aw+1)'(1);
      if (pop_i)  rptr_q <= rptr_q + (Aw+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/r5p_trace_encoder.sv
// Retired-instruction trace encoder: assembles one record per fetched instruction
// from IFU/LSU/GPR activity, buffers closed records and streams them to a sink.
module r5p_trace_encoder
  import r5p_trace_encoder_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter bit          LsuEn = 1'b1,
  parameter int unsigned CntW  = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                ifu_trn_i,
  input  logic [XLEN-1:0]     ifu_adr_i,
  input  logic [31:0]         ifu_rdt_i,
  input  logic                lsu_trn_i,
  input  logic                lsu_wen_i,
  input  logic [XLEN-1:0]     lsu_adr_i,
  input  logic [XLEN-1:0]     lsu_wdt_i,
  input  logic [XLEN-1:0]     lsu_rdt_i,
  input  logic                gpr_wen_i,
  input  logic [GLOG-1:0]     gpr_wid_i,
  input  logic [XLEN-1:0]     gpr_wdt_i,
  r5p_trace_encoder_if.master trc,
  output logic [CntW-1:0]     cnt_ret_o,
  output logic [CntW-1:0]     cnt_drp_o,
  output logic                ovf_o
);

  rec_t            rec_q, rec_d, cur_rec;
  logic            open_q, open_d;
  logic            ifu_pend_q;
  logic [XLEN-1:0] ifu_adr_q;
  logic            lsu_pend_q, lsu_wen_q;
  logic [XLEN-1:0] lsu_adr_q, lsu_wdt_q;
  logic [CntW-1:0] cnt_ret_q, cnt_drp_q;
  logic            ovf_q;
  logic            fetch_rsp, close, pop, push, drop, fifo_full, fifo_empty;
  logic [$bits(rec_t)-1:0] fifo_rdata;

  always_comb begin
    // Open record with this cycle's events merged; a closing record takes them too.
    cur_rec = rec_q;
    if (gpr_wen_i && (gpr_wid_i != '0)) begin
      cur_rec.gpr_vld = 1'b1;
      cur_rec.gpr_idx = gpr_wid_i;
      cur_rec.gpr_dat = gpr_wdt_i;
    end
    if (lsu_pend_q) begin
      cur_rec.mem_vld = 1'b1;
      cur_rec.mem_wen = lsu_wen_q;
      cur_rec.mem_adr = lsu_adr_q;
      cur_rec.mem_dat = lsu_wen_q ? lsu_wdt_q : lsu_rdt_i;
    end

    fetch_rsp = ifu_pend_q && en_i;
    close     = open_q && (fetch_rsp || !en_i);

    open_d = open_q;
    rec_d  = rec_q;
    if (fetch_rsp) begin
      open_d      = 1'b1;
      rec_d       = '0;
      rec_d.pc    = ifu_adr_q;
      rec_d.siz   = opsiz(ifu_rdt_i);
      rec_d.ins   = (rec_d.siz == Siz4) ? ifu_rdt_i : {16'h0000, ifu_rdt_i[15:0]};
    end else if (!en_i) begin
      open_d = 1'b0;
    end else if (open_q) begin
      rec_d = cur_rec;
    end
  end

  assign pop  = trc.vld && trc.rdy;
  assign push = close && (!fifo_full || pop);
  assign drop = close && fifo_full && !pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ifu_pend_q <= 1'b0;
      ifu_adr_q  <= '0;
      lsu_pend_q <= 1'b0;
      lsu_wen_q  <= 1'b0;
      lsu_adr_q  <= '0;
      lsu_wdt_q  <= '0;
      open_q     <= 1'b0;
      rec_q      <= '0;
      cnt_ret_q  <= '0;
      cnt_drp_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ifu_pend_q <= ifu_trn_i;
      if (ifu_trn_i) ifu_adr_q <= ifu_adr_i;
      lsu_pend_q <= lsu_trn_i && LsuEn;
      if (lsu_trn_i) begin
        lsu_wen_q <= lsu_wen_i;
        lsu_adr_q <= lsu_adr_i;
        lsu_wdt_q <= lsu_wdt_i;
      end
      open_q <= open_d;
      rec_q  <= rec_d;
      if (close) cnt_ret_q <= cnt_ret_q + CntW'(1);
      if (drop) begin
        cnt_drp_q <= cnt_drp_q + CntW'(1);
        ovf_q     <= 1'b1;
      end
    end
  end

  r5p_trace_encoder_fifo #(
    .Depth (Depth),
    .Width ($bits(rec_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (cur_rec),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign trc.vld   = !fifo_empty;
  assign trc.rec   = rec_t'(fifo_rdata);
  assign cnt_ret_o = cnt_ret_q;
  assign cnt_drp_o = cnt_drp_q;
  assign ovf_o     = ovf_q;

endmodule
